// File: rtl/nb_ctrl_pkg.sv
// Shared definitions for the instruction-decode controller and its code sequencer:
// field widths, opcodes, instruction word layout and sequencer states.
package nb_ctrl_pkg;

    localparam int OP_SIZE      = 4;
    localparam int PARAM_A_SIZE = 4;
    localparam int PARAM_B_SIZE = 4;

    localparam logic [OP_SIZE-1:0] SET_ACT_DENSE     = 4'd1;
    localparam logic [OP_SIZE-1:0] SET_COST          = 4'd2;
    localparam logic [OP_SIZE-1:0] LOAD_WEIGHT       = 4'd3;
    localparam logic [OP_SIZE-1:0] LOAD_INPUT_LABEL  = 4'd4;
    localparam logic [OP_SIZE-1:0] SET_LEARNING_RATE = 4'd5;
    localparam logic [OP_SIZE-1:0] UPDATE_WEIGHT     = 4'd6;
    localparam logic [OP_SIZE-1:0] STALL             = 4'd7;
    localparam logic [OP_SIZE-1:0] LOAD_Z            = 4'd8;

    typedef struct packed {
        logic [OP_SIZE-1:0]      op;
        logic [PARAM_A_SIZE-1:0] param_a;
        logic [PARAM_B_SIZE-1:0] param_b;
    } instr_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_RUN,
        ST_DONE
    } seq_state_t;

endpackage

// File: rtl/code_memory.sv
// Program store: one synchronous write port and one combinational read port.
// Out-of-range write addresses are dropped rather than aliased.
module code_memory #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int WIDTH  = 12
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [ADDR_W:0]  wr_addr_ext;
    logic             wr_addr_ok;

    assign wr_addr_ext = {1'b0, wr_addr};
    assign wr_addr_ok  = (wr_addr_ext < DEPTH[ADDR_W:0]);

    always_ff @(posedge clk) begin
        if (wr_en && wr_addr_ok) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/code_sequencer.sv
// Steps through the program memory for the decode controller: fetches a line,
// counts cycles spent on it, and advances/rewinds on the controller's request.
module code_sequencer #(
    parameter int OP_SIZE      = nb_ctrl_pkg::OP_SIZE,
    parameter int PARAM_A_SIZE = nb_ctrl_pkg::PARAM_A_SIZE,
    parameter int PARAM_B_SIZE = nb_ctrl_pkg::PARAM_B_SIZE,
    parameter int CODE_DEPTH   = 64,
    parameter int ADDR_W       = $clog2(CODE_DEPTH)
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      prog_we,
    input  logic [ADDR_W-1:0]                         prog_addr,
    input  logic [OP_SIZE+PARAM_A_SIZE+PARAM_B_SIZE-1:0] prog_data,
    input  logic [ADDR_W:0]                           prog_len,
    input  logic                                      start,
    input  logic                                      count_reset,
    input  logic                                      code_reset,
    input  logic                                      code_active,
    output logic [OP_SIZE-1:0]                        op,
    output logic [PARAM_A_SIZE-1:0]                   param_a,
    output logic [PARAM_B_SIZE-1:0]                   param_b,
    output logic [PARAM_A_SIZE+PARAM_B_SIZE-1:0]      param_c,
    output logic [31:0]                               code_count,
    output logic                                      enable,
    output logic [ADDR_W-1:0]                         pc,
    output logic                                      busy,
    output logic                                      done
);

    import nb_ctrl_pkg::*;

    localparam int INSTR_W = OP_SIZE + PARAM_A_SIZE + PARAM_B_SIZE;

    seq_state_t         state_reg, state_next;
    logic [ADDR_W-1:0]  pc_reg, pc_next;
    logic [ADDR_W:0]    len_reg, len_next;
    logic [INSTR_W-1:0] instr_reg, instr_next;
    logic [31:0]        count_reg, count_next;

    logic [ADDR_W-1:0]  rd_addr;
    logic [INSTR_W-1:0] rd_data;
    logic               mem_we;
    logic               last_line;

    code_memory #(
        .DEPTH  (CODE_DEPTH),
        .ADDR_W (ADDR_W),
        .WIDTH  (INSTR_W)
    ) u_code_memory (
        .clk     (clk),
        .wr_en   (mem_we),
        .wr_addr (prog_addr),
        .wr_data (prog_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    assign last_line = ({1'b0, pc_reg} == (len_reg - 1'b1));

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        len_next   = len_reg;
        instr_next = instr_reg;
        count_next = count_reg;
        rd_addr    = pc_reg;
        mem_we     = 1'b0;

        case (state_reg)
            ST_IDLE, ST_DONE: begin
                // Program loading is only safe while nothing is executing.
                mem_we = prog_we;
                if (start) begin
                    len_next   = prog_len;
                    pc_next    = '0;
                    state_next = (prog_len == '0) ? ST_DONE : ST_FETCH;
                end
            end
            ST_FETCH: begin
                instr_next = rd_data;
                count_next = '0;
                state_next = ST_RUN;
            end
            ST_RUN: begin
                if (code_reset) begin
                    rd_addr    = '0;
                    pc_next    = '0;
                    instr_next = rd_data;
                    count_next = '0;
                end else if (code_active) begin
                    if (last_line) begin
                        // Last line keeps its instruction and count visible in DONE.
                        state_next = ST_DONE;
                    end else begin
                        rd_addr    = pc_reg + 1'b1;
                        pc_next    = pc_reg + 1'b1;
                        instr_next = rd_data;
                        count_next = '0;
                    end
                end else if (count_reset) begin
                    count_next = '0;
                end else if (count_reg != '1) begin
                    count_next = count_reg + 32'd1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            pc_reg    <= '0;
            len_reg   <= '0;
            instr_reg <= '0;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            len_reg   <= len_next;
            instr_reg <= instr_next;
            count_reg <= count_next;
        end
    end

    assign op         = instr_reg[INSTR_W-1 -: OP_SIZE];
    assign param_a    = instr_reg[PARAM_A_SIZE+PARAM_B_SIZE-1 -: PARAM_A_SIZE];
    assign param_b    = instr_reg[PARAM_B_SIZE-1:0];
    assign param_c    = {param_a, param_b};
    assign code_count = count_reg;
    assign pc         = pc_reg;
    assign enable     = (state_reg == ST_RUN);
    assign busy       = (state_reg == ST_FETCH) || (state_reg == ST_RUN);
    assign done       = (state_reg == ST_DONE);

endmodule
